// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage.
// Bus structs define the field layout of the stage boundaries.
package mem_stage_pkg;

   localparam int ES2MS_WD = 173;
   localparam int MS2WS_WD = 167;
   localparam int MSFWD_WD = 39;

   localparam int LD_B  = 0;
   localparam int LD_H  = 1;
   localparam int LD_W  = 2;
   localparam int LD_BU = 3;
   localparam int LD_HU = 4;

   localparam logic [5:0] ECODE_ALE = 6'h09;

   // Field offsets of the incoming bus (LSB of each field)
   localparam int ES_PC_LSB     = 0;
   localparam int ES_ALU_LSB    = 32;
   localparam int ES_DEST_LSB   = 64;
   localparam int ES_GRWE_BIT   = 69;
   localparam int ES_RFM_BIT    = 70;
   localparam int ES_LDOP_LSB   = 71;
   localparam int ES_WMASK_LSB  = 76;
   localparam int ES_CSRNUM_LSB = 108;
   localparam int ES_CSRWE_BIT  = 122;
   localparam int ES_CSRRE_BIT  = 123;
   localparam int ES_ECODE_LSB  = 124;
   localparam int ES_WVAL_LSB   = 130;
   localparam int ES_ERTN_BIT   = 162;
   localparam int ES_EX_BIT     = 163;
   localparam int ES_ESUB_LSB   = 164;

   typedef struct packed {
      logic [8:0]  esubcode;
      logic        ex;
      logic        ertn;
      logic [31:0] csr_wvalue;
      logic [5:0]  ecode;
      logic        csr_re;
      logic        csr_we;
      logic [13:0] csr_num;
      logic [31:0] csr_wmask;
      logic [4:0]  load_op;
      logic        res_from_mem;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] alu_result;
      logic [31:0] pc;
   } es_to_ms_t;

   typedef struct packed {
      logic [8:0]  esubcode;
      logic        ex;
      logic        ertn;
      logic [31:0] csr_wvalue;
      logic [5:0]  ecode;
      logic        csr_re;
      logic        csr_we;
      logic [13:0] csr_num;
      logic [31:0] csr_wmask;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] final_result;
      logic [31:0] pc;
   } ms_to_ws_t;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment with sign/zero extension.
// Byte lane from the full offset, half lane from off[1].
module mem_load_align
   import mem_stage_pkg::*;
(
   input  logic [4:0]  i_load_op,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
   assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

   always_comb begin
      o_data = i_rdata;
      unique case (1'b1)
         i_load_op[LD_B]:  o_data = {{24{w_byte[7]}}, w_byte};
         i_load_op[LD_H]:  o_data = {{16{w_half[15]}}, w_half};
         i_load_op[LD_W]:  o_data = i_rdata;
         i_load_op[LD_BU]: o_data = {24'h0, w_byte};
         i_load_op[LD_HU]: o_data = {16'h0, w_half};
         default:          o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: latches the execute bus, holds SRAM data under stall.
// Optional misaligned-load exception when MEM_ALE_CHECK_EN is defined.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ES_TO_MS_BUS_WD = ES2MS_WD,
   parameter int MS_TO_WS_BUS_WD = MS2WS_WD,
   parameter int MS_FWD_BUS_WD   = MSFWD_WD
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       ws_allowin,
   output logic                       ms_allowin,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus,
   input  logic [31:0]                data_sram_rdata,
   input  logic                       ms_flush_pipe,
   output logic                       ms_ex
);

   es_to_ms_t   r_es;
   logic        r_valid;
   logic        r_held;
   logic [31:0] r_hold;

   logic        w_ready_go;
   logic        w_accept;
   logic [31:0] w_rdata;
   logic [31:0] w_ld;
   logic [31:0] w_result;
   logic [1:0]  w_off;
   logic        w_ale;
   logic        w_ex;
   logic        w_gr_we;
   ms_to_ws_t   w_ws;

   assign w_ready_go = 1'b1;
   assign ms_allowin = ~r_valid | (w_ready_go & ws_allowin);
   assign w_accept   = es_to_ms_valid & ms_allowin;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_valid <= 1'b0;
      end else if (ms_flush_pipe) begin
         r_valid <= 1'b0;
      end else if (ms_allowin) begin
         r_valid <= es_to_ms_valid;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_es <= '0;
      end else if (w_accept) begin
         r_es <= es_to_ms_t'(es_to_ms_bus);
      end
   end

   // SRAM data is only valid the first cycle; park it if WB stalls us
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_held <= 1'b0;
         r_hold <= '0;
      end else if (w_accept | ms_flush_pipe) begin
         r_held <= 1'b0;
      end else if (r_valid & ~r_held & ~ws_allowin) begin
         r_held <= 1'b1;
         r_hold <= data_sram_rdata;
      end
   end

   assign w_rdata = r_held ? r_hold : data_sram_rdata;
   assign w_off   = r_es.alu_result[1:0];

   mem_load_align u_align (
      .i_load_op (r_es.load_op),
      .i_off     (w_off),
      .i_rdata   (w_rdata),
      .o_data    (w_ld)
   );

   assign w_result = r_es.res_from_mem ? w_ld : r_es.alu_result;

`ifdef MEM_ALE_CHECK_EN
   assign w_ale = r_es.res_from_mem & ~r_es.ex &
      (((r_es.load_op[LD_H] | r_es.load_op[LD_HU]) & w_off[0]) |
       (r_es.load_op[LD_W] & (|w_off)));
`else
   assign w_ale = 1'b0;
`endif

   assign w_ex    = r_es.ex | w_ale;
   assign w_gr_we = r_es.gr_we & ~w_ale;

   always_comb begin
      w_ws              = '0;
      w_ws.esubcode     = w_ale ? 9'h0 : r_es.esubcode;
      w_ws.ex           = w_ex;
      w_ws.ertn         = r_es.ertn;
      w_ws.csr_wvalue   = r_es.csr_wvalue;
      w_ws.ecode        = w_ale ? ECODE_ALE : r_es.ecode;
      w_ws.csr_re       = r_es.csr_re;
      w_ws.csr_we       = r_es.csr_we;
      w_ws.csr_num      = r_es.csr_num;
      w_ws.csr_wmask    = r_es.csr_wmask;
      w_ws.gr_we        = w_gr_we;
      w_ws.dest         = r_es.dest;
      w_ws.final_result = w_result;
      w_ws.pc           = r_es.pc;
   end

   assign ms_to_ws_bus   = w_ws;
   assign ms_to_ws_valid = r_valid & w_ready_go & ~ms_flush_pipe;
   assign ms_ex          = r_valid & (w_ex | r_es.ertn);
   assign ms_fwd_bus     = {r_es.csr_re & r_valid, r_valid & w_gr_we,
                            r_es.dest, w_result};

endmodule

// File: tb/tb_mem_stage.sv
// Randomised bench for mem_stage against a transaction-level model.
// Directed loads, stall, flush and async reset cases precede the random run.
module tb_mem_stage;

   logic         clk;
   logic         resetn;
   logic         ws_allowin;
   logic         ms_allowin;
   logic         es_to_ms_valid;
   logic [172:0] es_to_ms_bus;
   logic         ms_to_ws_valid;
   logic [166:0] ms_to_ws_bus;
   logic [38:0]  ms_fwd_bus;
   logic [31:0]  data_sram_rdata;
   logic         ms_flush_pipe;
   logic         ms_ex;

   int errors = 0;
   int checks = 0;

   mem_stage dut (
      .clk             (clk),
      .resetn          (resetn),
      .ws_allowin      (ws_allowin),
      .ms_allowin      (ms_allowin),
      .es_to_ms_valid  (es_to_ms_valid),
      .es_to_ms_bus    (es_to_ms_bus),
      .ms_to_ws_valid  (ms_to_ws_valid),
      .ms_to_ws_bus    (ms_to_ws_bus),
      .ms_fwd_bus      (ms_fwd_bus),
      .data_sram_rdata (data_sram_rdata),
      .ms_flush_pipe   (ms_flush_pipe),
      .ms_ex           (ms_ex)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [166:0] act,
                      input logic [166:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [172:0] mk(input logic [4:0] ld,
      input logic rfm, input logic gw, input logic [4:0] dest,
      input logic [31:0] alu, input logic ertn);
      return {9'h0, 1'b0, ertn, 32'h0, 6'h0, 1'b0, 1'b0, 14'h0,
              32'h0, ld, rfm, gw, dest, alu, 32'h1c00_0040};
   endfunction

   // Expected outgoing bus for an instruction given the word it loaded
   function automatic logic [166:0] exp_ws(input logic [172:0] b,
                                           input logic [31:0] mem);
      logic [31:0] alu;
      logic [31:0] res;
      logic [31:0] sh;
      logic [4:0]  ld;
      logic [1:0]  off;
      logic        ex;
      logic [5:0]  ec;
      logic [8:0]  es;
      logic        gw;
      alu = b[63:32];
      ld  = b[75:71];
      off = alu[1:0];
      res = mem;
      if (ld[0]) begin
         sh  = mem >> (8 * off);
         res = {{24{sh[7]}}, sh[7:0]};
      end else if (ld[1]) begin
         sh  = mem >> (16 * off[1]);
         res = {{16{sh[15]}}, sh[15:0]};
      end else if (ld[3]) begin
         sh  = mem >> (8 * off);
         res = {24'h0, sh[7:0]};
      end else if (ld[4]) begin
         sh  = mem >> (16 * off[1]);
         res = {16'h0, sh[15:0]};
      end
      if (!b[70]) res = alu;
      ex = b[163];
      ec = b[129:124];
      es = b[172:164];
      gw = b[69];
`ifdef MEM_ALE_CHECK_EN
      if (b[70] && !ex &&
          (((ld[1] || ld[4]) && off[0]) || (ld[2] && off != 2'd0))) begin
         ex = 1'b1;
         ec = 6'h09;
         es = 9'h0;
         gw = 1'b0;
      end
`endif
      return {es, ex, b[162], b[161:130], ec, b[123], b[122],
              b[121:108], b[107:76], gw, b[68:64], res, b[31:0]};
   endfunction

   // Model: one instruction slot plus the word seen in its first cycle
   logic         m_valid = 1'b0;
   logic         m_first = 1'b0;
   logic [172:0] m_bus   = '0;
   logic [31:0]  m_data  = '0;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_valid <= 1'b0;
         m_first <= 1'b0;
      end else begin
         if (m_valid && m_first) m_data <= data_sram_rdata;
         m_first <= 1'b0;
         if (ms_flush_pipe) begin
            m_valid <= 1'b0;
         end else if (!m_valid || ws_allowin) begin
            m_valid <= es_to_ms_valid;
            if (es_to_ms_valid) begin
               m_bus   <= es_to_ms_bus;
               m_first <= 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [31:0]  mem;
      logic [166:0] ews;
      mem = m_first ? data_sram_rdata : m_data;
      ews = exp_ws(m_bus, mem);
      chk("allowin", 167'(ms_allowin), 167'(!m_valid || ws_allowin));
      chk("to_ws_valid", 167'(ms_to_ws_valid),
          167'(m_valid && !ms_flush_pipe));
      chk("ms_ex", 167'(ms_ex), 167'(m_valid && (ews[157] || ews[156])));
      chk("fwd_valid", 167'(ms_fwd_bus[38:37]),
          167'({m_valid & ews[117], m_valid & ews[69]}));
      if (m_valid) begin
         chk("ws_bus", ms_to_ws_bus, ews);
         chk("fwd_data", 167'(ms_fwd_bus[36:0]),
             167'({ews[68:64], ews[63:32]}));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [172:0] rand_bus();
      logic        rfm;
      logic [4:0]  ld;
      logic [31:0] r0, r1, r2, r3, r4;
      logic        ex, ertn;
      rfm  = 1'($urandom_range(0, 1));
      ld   = rfm ? 5'(5'b1 << $urandom_range(0, 4)) : 5'h0;
      ex   = ($urandom_range(0, 9) == 0);
      ertn = ($urandom_range(0, 9) == 0);
      r0 = $urandom; r1 = $urandom; r2 = $urandom;
      r3 = $urandom; r4 = $urandom;
      return {r0[8:0], ex, ertn, r1, r0[14:9], r0[15], r0[16],
              r0[30:17], r2, ld, rfm, r0[31], r4[4:0], r3, r4};
   endfunction

   initial begin
      resetn          = 1'b0;
      es_to_ms_valid  = 1'b0;
      es_to_ms_bus    = '0;
      ws_allowin      = 1'b1;
      ms_flush_pipe   = 1'b0;
      data_sram_rdata = '0;
      step();
      step();
      #3;
      chk("rst_to_ws_valid", 167'(ms_to_ws_valid), 167'(0));
      chk("rst_ms_ex", 167'(ms_ex), 167'(0));
      chk("rst_fwd_valid", 167'(ms_fwd_bus[38:37]), 167'(0));
      chk("rst_allowin", 167'(ms_allowin), 167'(1));
      step();
      resetn = 1'b1;

      // ld.b of byte 3
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(5'b00001, 1'b1, 1'b1, 5'd3, 32'h1000_0003, 1'b0);
      step();
      es_to_ms_valid  = 1'b0;
      data_sram_rdata = 32'h80FF_1234;
      #3;
      chk("ldb_result", 167'(ms_to_ws_bus[63:32]), 167'(32'hFFFF_FF80));
      chk("ldb_valid", 167'(ms_to_ws_valid), 167'(1));

      // ld.hu across a 3-cycle stall, SRAM data changes mid-stall
      step();
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(5'b10000, 1'b1, 1'b1, 5'd4, 32'h0000_2002, 1'b0);
      step();
      es_to_ms_valid  = 1'b0;
      ws_allowin      = 1'b0;
      data_sram_rdata = 32'h9ABC_5678;
      step();
      data_sram_rdata = 32'h0;
      step();
      step();
      ws_allowin = 1'b1;
      #3;
      chk("ldhu_result", 167'(ms_to_ws_bus[63:32]), 167'(32'h0000_9ABC));
      chk("ldhu_valid", 167'(ms_to_ws_valid), 167'(1));

      // ALU result forwarding
      step();
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(5'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 1'b0);
      step();
      es_to_ms_valid = 1'b0;
      #3;
      chk("alu_fwd", 167'(ms_fwd_bus),
          167'({1'b0, 1'b1, 5'd5, 32'h0000_1234}));
      chk("alu_valid", 167'(ms_to_ws_valid), 167'(1));

      // Flush beats a simultaneous acceptance
      step();
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(5'b0, 1'b0, 1'b1, 5'd6, 32'h0000_00AA, 1'b0);
      step();
      es_to_ms_bus  = mk(5'b0, 1'b0, 1'b1, 5'd7, 32'h0000_00BB, 1'b0);
      ms_flush_pipe = 1'b1;
      #3;
      chk("flush_to_ws_valid", 167'(ms_to_ws_valid), 167'(0));
      step();
      ms_flush_pipe  = 1'b0;
      es_to_ms_valid = 1'b0;
      ws_allowin     = 1'b0;
      #3;
      chk("flush_next_valid", 167'(ms_to_ws_valid), 167'(0));
      chk("flush_next_allowin", 167'(ms_allowin), 167'(1));

      // ertn held under stall, then async reset mid-stall
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(5'b0, 1'b0, 1'b1, 5'd8, 32'h0, 1'b1);
      step();
      es_to_ms_valid = 1'b0;
      #3;
      chk("ertn_ms_ex", 167'(ms_ex), 167'(1));
      step();
      #3;
      chk("ertn_ms_ex_held", 167'(ms_ex), 167'(1));
      step();
      #2;
      resetn = 1'b0;
      #1;
      chk("async_to_ws_valid", 167'(ms_to_ws_valid), 167'(0));
      chk("async_ms_ex", 167'(ms_ex), 167'(0));
      chk("async_fwd_valid", 167'(ms_fwd_bus[38:37]), 167'(0));
      step();
      step();
      resetn     = 1'b1;
      ws_allowin = 1'b1;

`ifdef MEM_ALE_CHECK_EN
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(5'b00100, 1'b1, 1'b1, 5'd9, 32'h0000_1002, 1'b0);
      step();
      es_to_ms_valid = 1'b0;
      #3;
      chk("ale_ex", 167'(ms_to_ws_bus[157]), 167'(1));
      chk("ale_ecode", 167'(ms_to_ws_bus[123:118]), 167'(6'h09));
      chk("ale_gr_we", 167'(ms_to_ws_bus[69]), 167'(0));
      chk("ale_ms_ex", 167'(ms_ex), 167'(1));
      step();
`endif

      for (int i = 0; i < 3000; i++) begin
         resetn          = ($urandom_range(0, 299) != 0);
         es_to_ms_valid  = ($urandom_range(0, 9) < 7);
         es_to_ms_bus    = rand_bus();
         ws_allowin      = ($urandom_range(0, 9) < 6);
         ms_flush_pipe   = ($urandom_range(0, 19) == 0);
         data_sram_rdata = $urandom;
         step();
      end
      resetn = 1'b1;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage, directly downstream of the execute stage and upstream of write-back.
- Latches the execute-to-memory bus and receives synchronous data-SRAM read data one cycle after the execute-stage request.
- Holds that read data across write-back back-pressure, then aligns and sign/zero-extends loads.
- Forwards the result to decode and reports exception/ertn presence back to execute for store suppression.

Parameters:
- ES_TO_MS_BUS_WD, 173: width of the incoming bus.
- MS_TO_WS_BUS_WD, 167: width of the outgoing bus.
- MS_FWD_BUS_WD, 39: width of the forward bus.

Ports:
- clk  in  1: sole clock.
- resetn  in  1: reset, asynchronous, active-low.
- ws_allowin  in  1: write-back can accept.
- ms_allowin  out  1: this stage can accept.
- es_to_ms_valid  in  1: execute offers an instruction.
- es_to_ms_bus  in  173, packed MSB to LSB: esubcode[9], ex, ertn, csr_wvalue[32], ecode[6], csr_re, csr_we, csr_num[14], csr_wmask[32], load_op[5], res_from_mem, gr_we, dest[5], alu_result[32], pc[32].
- ms_to_ws_valid  out  1: instruction offered to write-back.
- ms_to_ws_bus  out  167, packed MSB to LSB: esubcode, ex, ertn, csr_wvalue, ecode, csr_re, csr_we, csr_num, csr_wmask, gr_we, dest, final_result[32], pc.
- ms_fwd_bus  out  39: {csr_re&ms_valid, ms_valid&gr_we, dest, final_result}.
- data_sram_rdata  in  32: read data, valid the first cycle after acceptance.
- ms_flush_pipe  in  1: exception/ertn commit in write-back.
- ms_ex  out  1: ms_valid & (ex | ertn).

Behaviour:
- Reset (resetn low, asynchronous): ms_valid=0, rdata_held=0, hold register=0, latched bus=0.
  - Consequently ms_to_ws_valid=0, ms_ex=0, forward valid bits=0.
- Handshake:
  - ms_ready_go=1 always.
  - ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
  - ms_to_ws_valid = ms_valid & ms_ready_go & ~ms_flush_pipe.
- Valid register:
  - On ms_flush_pipe, ms_valid<=0; flush has priority over acceptance.
  - Otherwise, if ms_allowin, ms_valid<=es_to_ms_valid.
- Bus latch: loads only when es_to_ms_valid & ms_allowin.
- Read-data hold:
  - rdata_held<=0 whenever a new instruction is accepted, or on flush.
  - When ms_valid & ~rdata_held & ~ws_allowin: capture data_sram_rdata into the hold register, then set rdata_held<=1.
  - mem_rdata = rdata_held ? hold register : data_sram_rdata.
  - A stall of N cycles still delivers the first-cycle data.
- Load alignment, off = alu_result[1:0]:
  - load_op[0] ld.b: sign-extend byte off.
  - load_op[1] ld.h: sign-extend half off[1].
  - load_op[2] ld.w: whole word.
  - load_op[3] ld.bu: zero-extend byte off.
  - load_op[4] ld.hu: zero-extend half off[1].
- final_result = res_from_mem ? aligned load : alu_result.
- Latency:
  - One cycle from acceptance to offer when ws_allowin=1.
  - Bus fields other than final_result are forwarded unchanged.
- Simultaneous accept-while-held: new instruction clears rdata_held the same edge its bus latches.
- Flush mid-stall: drop the instruction and discard held data.

Optional Feature:
- Macro: MEM_ALE_CHECK_EN.
- Defined: a load with (ld.h|ld.hu & off[0]) or (ld.w & off!=0), and incoming ex=0, is forced to:
  - ex=1, ecode=6'h09, esubcode=0, gr_we=0, forward valid=0;
  - ms_ex asserts the same cycle.
- Undefined: no check; misaligned halfwords use off[1] and ld.w ignores off.

Decomposition:
- Shared package/header holds:
  - bus width constants;
  - load_op bit indices LD_B..LD_HU;
  - ecode constants (ECODE_ALE=6'h09);
  - bus field offsets.
- Sub-module: mem_load_align, combinational: (load_op, off, rdata) -> aligned value.

Test Plan:
- ld.b, alu_result=0x1000_0003, rdata=0x80FF_1234, ws_allowin=1 -> final_result=0xFFFF_FF80 one cycle later.
- ld.hu, off=2, rdata=0x9ABC_5678; ws_allowin low 3 cycles, rdata changes to 0 after cycle 1 -> final_result=0x0000_9ABC when released.
- ALU op, alu_result=0x1234, gr_we=1, dest=5 -> ms_fwd_bus={0,1,5,0x1234}, ms_to_ws_valid=1.
- ms_flush_pipe asserted while ms_valid=1 and es_to_ms_valid=1 -> ms_to_ws_valid=0 that cycle; ms_valid=0 next; new instruction not accepted.
- Incoming ertn=1 -> ms_ex=1 while held; deassert resetn mid-stall -> all valids 0 immediately, without waiting for a clock edge.
- With MEM_ALE_CHECK_EN: ld.w, off=2 -> ex=1, ecode=0x09, gr_we=0, ms_ex=1.
